// File: rtl/ss_sequencer.sv
// Save-state sequencer.
// Walks device indices over the ss2device bus. On save it queries each device
// for its size, reads every word and streams {header, data} out. On restore it
// consumes that same stream and writes the words back through the bus.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for save_start / restore_start, ss_idx = FF
// QUERY     | size-query strobe to device idx
// QWAIT     | waiting for query ack; timeout means the device is absent
// HDR       | save: present header word on out stream
// RD        | save: read strobe at addr
// RWAIT     | save: waiting for read ack; timeout is an error
// PUSH      | save: present read word on out stream
// FETCH_HDR | restore: accept and check header word from in stream
// FETCH     | restore: accept one data word from in stream
// WR        | restore: write strobe at addr with fetched word
// WWAIT     | restore: waiting for write ack; timeout is an error
// NEXT      | step to next device index or finish
// DONE      | one-cycle done pulse
// ERR       | one-cycle error exit, error stays set until next start

module ss_sequencer #(
  parameter int MAX_DEV     = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        save_start,
  input  logic        restore_start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] ss_data,
  output logic [23:0] ss_addr,
  output logic [7:0]  ss_idx,
  output logic        ss_write,
  output logic        ss_read,
  output logic        ss_query,
  input  logic        ss_ack,
  input  logic [63:0] ss_ack_data,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  typedef enum logic [3:0] {
    IDLE,
    QUERY,
    QWAIT,
    HDR,
    RD,
    RWAIT,
    PUSH,
    FETCH_HDR,
    FETCH,
    WR,
    WWAIT,
    NEXT,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0]  LAST_IDX  = 8'(MAX_DEV - 1);
  localparam logic [15:0] TMO_LOAD  = 16'(ACK_TIMEOUT);
  localparam logic [31:0] MAX_COUNT = 32'h0100_0000;

  state_t      state;
  state_t      state_nxt;
  logic        restore_mode;
  logic [7:0]  idx;
  logic [31:0] count;
  logic [31:0] addr;
  logic [31:0] addr_inc;
  logic [63:0] word;
  logic [15:0] tmr;
  logic        tmr_done;
  logic        start_any;
  logic        error_q;
  logic [63:0] header;

  assign addr_inc  = addr + 32'd1;
  assign tmr_done  = (tmr == 16'd0);
  assign start_any = save_start | restore_start;
  assign header    = {idx, 24'h0, count};

  assign ss_addr   = addr[23:0];
  assign ss_data   = word;
  assign out_data  = (state == HDR) ? header : word;
  assign error     = error_q;

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and bus/stream outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    ss_idx    = idx;
    ss_query  = 1'b0;
    ss_read   = 1'b0;
    ss_write  = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        ss_idx = 8'hFF;
        if (start_any) state_nxt = QUERY;
      end
      QUERY: begin
        ss_query  = 1'b1;
        state_nxt = QWAIT;
      end
      QWAIT: begin
        if (ss_ack) begin
          if (ss_ack_data[31:0] > MAX_COUNT) state_nxt = ERR;
          else if (restore_mode)             state_nxt = FETCH_HDR;
          else                               state_nxt = HDR;
        end else if (tmr_done) begin
          state_nxt = NEXT;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (count == 32'd0) ? NEXT : RD;
      end
      RD: begin
        ss_read   = 1'b1;
        state_nxt = RWAIT;
      end
      RWAIT: begin
        if (ss_ack)        state_nxt = PUSH;
        else if (tmr_done) state_nxt = ERR;
      end
      PUSH: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (addr_inc == count) ? NEXT : RD;
      end
      FETCH_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data[63:56] != idx || in_data[31:0] != count) state_nxt = ERR;
          else if (count == 32'd0)                             state_nxt = NEXT;
          else                                                 state_nxt = FETCH;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = WR;
      end
      WR: begin
        ss_write  = 1'b1;
        state_nxt = WWAIT;
      end
      WWAIT: begin
        if (ss_ack)        state_nxt = (addr_inc == count) ? NEXT : FETCH;
        else if (tmr_done) state_nxt = ERR;
      end
      NEXT: begin
        ss_idx    = 8'hFF;
        state_nxt = (idx == LAST_IDX) ? DONE : QUERY;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        ss_idx    = 8'hFF;
        state_nxt = IDLE;
      end
      ERR: begin
        busy      = 1'b0;
        ss_idx    = 8'hFF;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        ss_idx    = 8'hFF;
        state_nxt = IDLE;
      end
    endcase
  end

  // Device index, size, word address, data word and ack timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      restore_mode <= 1'b0;
      idx          <= 8'd0;
      count        <= 32'd0;
      addr         <= 32'd0;
      word         <= 64'd0;
      tmr          <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_any) begin
            restore_mode <= ~save_start;
            idx          <= 8'd0;
            addr         <= 32'd0;
          end
        end
        QUERY, RD, WR: tmr <= TMO_LOAD;
        QWAIT: begin
          if (ss_ack) begin
            count <= ss_ack_data[31:0];
            addr  <= 32'd0;
          end else if (!tmr_done) begin
            tmr <= tmr - 16'd1;
          end
        end
        RWAIT: begin
          if (ss_ack)         word <= ss_ack_data;
          else if (!tmr_done) tmr  <= tmr - 16'd1;
        end
        PUSH: begin
          if (out_ready) addr <= addr_inc;
        end
        FETCH: begin
          if (in_valid) word <= in_data;
        end
        WWAIT: begin
          if (ss_ack)         addr <= addr_inc;
          else if (!tmr_done) tmr  <= tmr - 16'd1;
        end
        NEXT: begin
          if (idx != LAST_IDX) idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Sticky error flag: set on entry to ERR, cleared by an accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (state == IDLE && start_any) begin
      error_q <= 1'b0;
    end else if (state_nxt == ERR) begin
      error_q <= 1'b1;
    end
  end

endmodule
